// File: rtl/sr_bank_pkg.sv
// Shared constants for the clocked SR latch bank: simultaneous-command policies
// and the per-channel command encoding {set, reset}.
package sr_bank_pkg;

    localparam int SIM_HOLD = 0;
    localparam int SIM_SET  = 1;
    localparam int SIM_RST  = 2;
    localparam int SIM_TOG  = 3;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_RST  = 2'b01,
        CMD_SET  = 2'b10,
        CMD_BOTH = 2'b11
    } cmd_e;

    // Next q when set and reset are both asserted and the command qualifies.
    function automatic logic resolve_both(input int mode, input logic q);
        case (mode)
            SIM_SET: return 1'b1;
            SIM_RST: return 1'b0;
            SIM_TOG: return ~q;
            default: return q;
        endcase
    endfunction

endpackage

// File: rtl/sr_filter_cell.sv
// One latch channel: optional input synchroniser, stability filter on the decoded
// command, simultaneous-command resolution and the registered q / change pulse.
module sr_filter_cell
    import sr_bank_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 3,
    parameter int   SIMUL_MODE  = SIM_RST,
    parameter logic INIT_Q      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_n_i,
    input  logic reset_n_i,
    output logic q_o,
    output logic qbar_o,
    output logic chg_o
);

    localparam int CW = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] FILT_MAX = CW'(FILT_CYCLES);

    if (FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_bad_filt
        $error("sr_filter_cell: FILT_CYCLES must be in 1..255");
    end
    if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("sr_filter_cell: SYNC_STAGES must be in 0..3");
    end

    logic set_s;
    logic rst_s;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign set_s = set_n_i;
        assign rst_s = reset_n_i;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] set_sync_q;
        logic [SYNC_STAGES-1:0] rst_sync_q;

        // Flops reset to 1 so a command held through reset must requalify.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                set_sync_q <= '1;
                rst_sync_q <= '1;
            end else begin
                set_sync_q[0] <= set_n_i;
                rst_sync_q[0] <= reset_n_i;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    set_sync_q[i] <= set_sync_q[i-1];
                    rst_sync_q[i] <= rst_sync_q[i-1];
                end
            end
        end

        assign set_s = set_sync_q[SYNC_STAGES-1];
        assign rst_s = rst_sync_q[SYNC_STAGES-1];
    end

    cmd_e          cmd;
    cmd_e          last_cmd_q, last_cmd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fire;
    logic          q_q, q_d;
    logic          chg_q;

    always_comb begin
        cmd        = cmd_e'({~set_s, ~rst_s});
        last_cmd_d = cmd;
        cnt_d      = cnt_q;
        q_d        = q_q;
        if (cmd != last_cmd_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q < FILT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Fire only on the edge the count arrives at the limit, never while saturated.
        fire = (cnt_d == FILT_MAX) && ((cnt_d != cnt_q) || (cmd != last_cmd_q));
        if (fire) begin
            case (cmd)
                CMD_SET:  q_d = 1'b1;
                CMD_RST:  q_d = 1'b0;
                CMD_BOTH: q_d = resolve_both(SIMUL_MODE, q_q);
                default:  q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            last_cmd_q <= CMD_IDLE;
            q_q        <= INIT_Q;
            chg_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            last_cmd_q <= last_cmd_d;
            q_q        <= q_d;
            chg_q      <= (q_d != q_q);
        end
    end

    assign q_o    = q_q;
    assign qbar_o = ~q_q;
    assign chg_o  = chg_q;

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of independent clocked, glitch-filtered SR latches; one sr_filter_cell per
// channel with outputs concatenated by channel index.
module sr_latch_bank
    import sr_bank_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter int                SYNC_STAGES = 2,
    parameter int                FILT_CYCLES = 3,
    parameter int                SIMUL_MODE  = SIM_RST,
    parameter logic [NUM_CH-1:0] INIT_Q      = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] set_n,
    input  logic [NUM_CH-1:0] reset_n,
    output logic [NUM_CH-1:0] q,
    output logic [NUM_CH-1:0] qbar,
    output logic [NUM_CH-1:0] chg
);

    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
        $error("sr_latch_bank: NUM_CH must be in 1..32");
    end
    if (SIMUL_MODE < SIM_HOLD || SIMUL_MODE > SIM_TOG) begin : g_bad_mode
        $error("sr_latch_bank: SIMUL_MODE must be in 0..3");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sr_filter_cell #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_CYCLES(FILT_CYCLES),
            .SIMUL_MODE (SIMUL_MODE),
            .INIT_Q     (INIT_Q[i])
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .set_n_i  (set_n[i]),
            .reset_n_i(reset_n[i]),
            .q_o      (q[i]),
            .qbar_o   (qbar[i]),
            .chg_o    (chg[i])
        );
    end

endmodule
